lcm_from_gcd: RTL and testbench

Downstream consumer stage for the `gcd` datapath. Takes an operand pair `(a, b)` together with the `gcd` block's `return_val` for that pair and computes `lcm = (a / g) * b` as a full 64-bit result. It uses a 32-cycle restoring divider followed by a 32-cycle shift-add multiplier. Transfer is by valid/ready handshake on both sides, so results can be queued behind a sink that stalls.

---
 rtl/lcm_from_gcd.sv | 144 ++++++++++++++
 tb/tb_lcm_from_gcd.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcm_from_gcd.sv
// LCM stage downstream of the gcd block: lcm = (a / g) * b via a 32-cycle
// restoring divider followed by a 32-cycle shift-add multiplier.
module lcm_from_gcd (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] gcd_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] lcm_val,
  output logic        err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StDiv  = 2'd1;
  localparam logic [1:0] StMul  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] div_q, div_d;
  logic [31:0] mplr_q, mplr_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] lcm_q, lcm_d;
  logic        err_q, err_d;

  // Divider step: quo_q doubles as dividend shift register and quotient collector.
  logic [32:0] rem_shift;
  logic [32:0] rem_sub;
  logic        fits;
  logic [31:0] quo_next;
  logic [32:0] rem_next;
  logic [63:0] acc_next;

  always_comb begin
    rem_shift = {rem_q[31:0], quo_q[31]};
    rem_sub   = rem_shift - {1'b0, div_q};
    fits      = (rem_shift >= {1'b0, div_q});
    quo_next  = {quo_q[30:0], fits};
    rem_next  = fits ? rem_sub : rem_shift;
    acc_next  = acc_q + (mplr_q[0] ? mcand_q : 64'd0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    lcm_d   = lcm_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          quo_d  = a;
          mplr_d = b;
          div_d  = gcd_val;
          rem_d  = 33'd0;
          cnt_d  = 6'd0;
          if (a == 32'd0 || b == 32'd0) begin
            state_d = StDone;
            lcm_d   = 64'd0;
            err_d   = 1'b0;
          end else if (gcd_val == 32'd0) begin
            state_d = StDone;
            lcm_d   = 64'd0;
            err_d   = 1'b1;
          end else begin
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        quo_d = quo_next;
        rem_d = rem_next;
        if (cnt_q == 6'd31) begin
          state_d = StMul;
          cnt_d   = 6'd0;
          mcand_d = {32'd0, quo_next};
          acc_d   = 64'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StMul: begin
        acc_d   = acc_next;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        if (cnt_q == 6'd31) begin
          state_d = StDone;
          lcm_d   = acc_next;
          err_d   = (rem_q != 33'd0);
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      quo_q   <= 32'd0;
      rem_q   <= 33'd0;
      div_q   <= 32'd0;
      mplr_q  <= 32'd0;
      mcand_q <= 64'd0;
      acc_q   <= 64'd0;
      lcm_q   <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      lcm_q   <= lcm_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign lcm_val   = lcm_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lcm_from_gcd.sv
// Self-checking bench for lcm_from_gcd: directed cases plus randomized jobs
// compared against an arithmetic reference model.
module tb_lcm_from_gcd;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] gcd_val;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] lcm_val;
  logic        err;

  int vectors;
  int miscompares;

  lcm_from_gcd dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .gcd_val   (gcd_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lcm_val   (lcm_val),
    .err       (err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] euclid(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 32'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Reference: special cases first, otherwise floor(a/g)*b with err on nonzero remainder.
  task automatic ref_model(input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] rg,
                           output logic [63:0] rl, output logic re, output int rlat);
    if (ra == 32'd0 || rb == 32'd0) begin
      rl = 64'd0; re = 1'b0; rlat = 1;
    end else if (rg == 32'd0) begin
      rl = 64'd0; re = 1'b1; rlat = 1;
    end else begin
      rl = 64'(ra / rg) * 64'(rb);
      re = (ra % rg) != 32'd0;
      rlat = 65;
    end
  endtask

  // Drive one triple and wait for out_valid; lat counts cycles from acceptance (1 = next cycle).
  task automatic do_job(input logic [31:0] ja, input logic [31:0] jb, input logic [31:0] jg,
                        output int lat, output logic [63:0] got_l, output logic got_e,
                        output bit timeout);
    int guard;
    guard = 0;
    timeout = 0;
    while (!in_ready && guard < 200) begin
      @(posedge sys_clk); #1;
      guard++;
    end
    a = ja; b = jb; gcd_val = jg; in_valid = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge sys_clk); #1;
      lat++;
    end
    if (!out_valid || guard >= 200) timeout = 1;
    got_l = lcm_val;
    got_e = err;
  endtask

  task automatic consume(output logic ir);
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    ir = in_ready;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    a = 32'd0; b = 32'd0; gcd_val = 32'd0;
    repeat (3) @(posedge sys_clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || lcm_val !== 64'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b vld=%b lcm=%h err=%b, want rdy=1 vld=0 lcm=0 err=0",
               in_ready, out_valid, lcm_val, err);
    end
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [6];
    logic [31:0] tbv [6];
    logic [31:0] tg [6];
    int lat, rlat;
    logic [63:0] l, rl;
    logic e, re, ir;
    bit to;
    ta  = '{32'd12, 32'd0, 32'd0, 32'd7, 32'd10, 32'hFFFFFFFF};
    tbv = '{32'd18, 32'd5, 32'd0, 32'd5, 32'd4,  32'hFFFFFFFE};
    tg  = '{32'd6,  32'd5, 32'd0, 32'd0, 32'd3,  32'd1};
    for (int i = 0; i < 6; i++) begin
      ref_model(ta[i], tbv[i], tg[i], rl, re, rlat);
      do_job(ta[i], tbv[i], tg[i], lat, l, e, to);
      vectors++;
      if (to || lat != rlat || l !== rl || e !== re) begin
        miscompares++;
        $display("FAIL directed[%0d]: got lat=%0d lcm=%h err=%b to=%0d, want lat=%0d lcm=%h err=%b",
                 i, lat, l, e, to, rlat, rl, re);
      end
      consume(ir);
      vectors++;
      if (ir !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL directed_idle[%0d]: got rdy=%b vld=%b, want rdy=1 vld=0", i, ir, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb, rg;
    int mode, lat, rlat;
    logic [63:0] l, rl;
    logic e, re, ir;
    bit to;
    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(1, 1000);
      rb = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(1, 1000);
      mode = $urandom_range(0, 9);
      if (mode == 0) ra = 32'd0;
      rg = euclid(ra, rb);
      if (mode == 1) rg = 32'd0;
      if (mode == 2) rg = $urandom_range(1, 50);
      ref_model(ra, rb, rg, rl, re, rlat);
      do_job(ra, rb, rg, lat, l, e, to);
      vectors++;
      if (to || lat != rlat || l !== rl || e !== re) begin
        miscompares++;
        $display("FAIL random[%0d] a=%h b=%h g=%h: got lat=%0d lcm=%h err=%b, want lat=%0d lcm=%h err=%b",
                 i, ra, rb, rg, lat, l, e, rlat, rl, re);
      end
      consume(ir);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] l;
    logic e;
    bit to;
    out_ready = 1'b0;
    do_job(32'd21, 32'd6, 32'd3, lat, l, e, to);
    vectors++;
    if (to || l !== 64'd42 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_result: got lcm=%h err=%b to=%0d, want lcm=2a err=0", l, e, to);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; gcd_val = 32'd0;
      @(posedge sys_clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || lcm_val !== 64'd42 || err !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got vld=%b lcm=%h err=%b rdy=%b, want vld=1 lcm=2a err=0 rdy=0",
                 i, out_valid, lcm_val, err, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    out_ready = 1'b1;
    a = 32'd0; b = 32'd9; gcd_val = 32'd9;
    in_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge sys_clk); #1;
      if (out_valid) pulses++;
    end
    in_valid = 1'b0;
    @(posedge sys_clk); #1;
    vectors++;
    if (pulses != 3) begin
      miscompares++;
      $display("FAIL back_to_back: got %0d results in 6 cycles, want 3", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int lat, pulses;
    logic [63:0] l;
    logic e, ir;
    bit to;
    out_ready = 1'b1;
    a = 32'd21; b = 32'd6; gcd_val = 32'd3; in_valid = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    repeat (40) @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || lcm_val !== 64'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got rdy=%b vld=%b lcm=%h err=%b, want rdy=1 vld=0 lcm=0 err=0",
               in_ready, out_valid, lcm_val, err);
    end
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge sys_clk); #1;
      if (out_valid) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_result: got %0d valid cycles, want 0", pulses);
    end
    do_job(32'd4, 32'd6, 32'd2, lat, l, e, to);
    vectors++;
    if (to || lat != 65 || l !== 64'd12 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_next: got lat=%0d lcm=%h err=%b, want lat=65 lcm=c err=0", lat, l, e);
    end
    consume(ir);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
